pes_seqgen: RTL and testbench

- Serial pattern transmitter; the sending end of the sequence-detection link.
- Loads a PW-bit pattern and shifts it out MSB-first, one bit per clock, on a single-bit line.
- Repeats the pattern a programmable number of times, with programmable idle-zero gaps between repetitions.
- Drives the `sequence_in` of the sequence detector (`iiitb_SDM`) in the lab top and in self-checking benches.

---
 rtl/pes_seqdet_pkg.sv | 18 +
 rtl/pes_seqgen_shreg.sv | 38 +++
 rtl/pes_seqgen.sv | 154 +++++++++++++++
 tb/tb_pes_seqgen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pes_seqdet_pkg.sv
// Shared definitions for the sequence-detection link: generator/detector state
// encodings, the default pattern and the default widths.
package pes_seqdet_pkg;

  localparam int DEF_PW = 4;
  localparam int DEF_CW = 4;
  localparam int DEF_GW = 4;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pes_seqgen_shreg.sv
// Parallel-load pattern register shifted out MSB-first. It rotates rather than
// shifts, so after PW shifts the pattern is back in place for the next repetition.
module pes_seqgen_shreg #(
  parameter int PW = 4,
  parameter int IW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [PW-1:0] load_data,
  output logic          msb,
  output logic          next_msb,
  output logic [IW-1:0] bit_idx
);

  logic [PW-1:0] data;
  logic [IW-1:0] idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      data <= load_data;
      idx  <= IW'(PW - 1);
    end else if (shift) begin
      data <= {data[PW-2:0], data[PW-1]};
      idx  <= (idx == '0) ? IW'(PW - 1) : idx - IW'(1);
    end
  end

  // next_msb is the bit that reaches the top after the next shift.
  assign msb      = data[PW-1];
  assign next_msb = data[PW-2];
  assign bit_idx  = idx;

endmodule

// File: rtl/pes_seqgen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first a programmable
// number of times, separated by programmable runs of idle zeros.
module pes_seqgen
  import pes_seqdet_pkg::*;
#(
  parameter int            PW              = DEF_PW,
  parameter int            CW              = DEF_CW,
  parameter int            GW              = DEF_GW,
  parameter logic [PW-1:0] DEFAULT_PATTERN = PW'(DEF_PATTERN)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          use_default,
  input  logic [PW-1:0] pattern_in,
  input  logic [CW-1:0] count_in,
  input  logic [GW-1:0] gap_in,
  output logic          sequence_out,
  output logic          bit_valid,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam int IW = (PW > 1) ? $clog2(PW) : 1;

  seq_state_e    state, state_next;
  logic [CW-1:0] reps_left, reps_next, reps_dec;
  logic [GW-1:0] gap_len;
  logic [GW-1:0] gap_cnt, gap_cnt_next;

  logic          load, shift;
  logic [PW-1:0] load_data;
  logic          sh_msb, sh_next_msb;
  logic [IW-1:0] bit_idx;

  logic          seq_next, valid_next, busy_next, done_next;

  assign load_data = use_default ? DEFAULT_PATTERN : pattern_in;
  assign dbg_state = state;

  pes_seqgen_shreg #(
    .PW (PW),
    .IW (IW)
  ) u_shreg (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (load_data),
    .msb       (sh_msb),
    .next_msb  (sh_next_msb),
    .bit_idx   (bit_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      reps_left    <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      sequence_out <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      reps_left    <= reps_next;
      gap_cnt      <= gap_cnt_next;
      if (load) gap_len <= gap_in;
      sequence_out <= seq_next;
      bit_valid    <= valid_next;
      busy         <= busy_next;
      done         <= done_next;
    end
  end

  // Outputs are computed for the cycle after the edge, so every output is a flop.
  always_comb begin
    state_next   = state;
    reps_next    = reps_left;
    gap_cnt_next = gap_cnt;
    load         = 1'b0;
    shift        = 1'b0;
    seq_next     = 1'b0;
    valid_next   = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    reps_dec     = (reps_left != '0) ? reps_left - CW'(1) : '0;

    case (state)
      IDLE: begin
        if (start) begin
          if (count_in != '0) begin
            load       = 1'b1;
            state_next = SEND;
            reps_next  = count_in;
            seq_next   = load_data[PW-1];
            valid_next = 1'b1;
            busy_next  = 1'b1;
          end else begin
            state_next = FIN;
            done_next  = 1'b1;
          end
        end
      end

      SEND: begin
        shift = 1'b1;
        if (bit_idx != '0) begin
          seq_next   = sh_next_msb;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end else begin
          reps_next = reps_dec;
          if (reps_dec == '0) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else if (gap_len == '0) begin
            seq_next   = sh_next_msb;
            valid_next = 1'b1;
            busy_next  = 1'b1;
          end else begin
            state_next   = GAP;
            gap_cnt_next = gap_len;
            busy_next    = 1'b1;
          end
        end
      end

      GAP: begin
        busy_next = 1'b1;
        // gap_cnt holds the idle cycles remaining including the current one.
        if (gap_cnt <= GW'(1)) begin
          state_next   = SEND;
          gap_cnt_next = '0;
          seq_next     = sh_msb;
          valid_next   = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt - GW'(1);
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pes_seqgen.sv
// Directed bench for pes_seqgen: a reference stream model fills a per-cycle
// expected queue that is popped and compared once per clock.
module tb_pes_seqgen;

  localparam int PW = 4;
  localparam int CW = 4;
  localparam int GW = 4;

  logic          clock;
  logic          reset;
  logic          start;
  logic          use_default;
  logic [PW-1:0] pattern_in;
  logic [CW-1:0] count_in;
  logic [GW-1:0] gap_in;
  logic          sequence_out;
  logic          bit_valid;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  // Expected entry: {state[1:0], sequence_out, bit_valid, busy, done}
  logic [5:0] exp_q[$];
  int checks;
  int errors;

  pes_seqgen dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .use_default  (use_default),
    .pattern_in   (pattern_in),
    .count_in     (count_in),
    .gap_in       (gap_in),
    .sequence_out (sequence_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {dbg_state, sequence_out, bit_valid, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [PW-1:0] pat, input int cnt, input int gap);
    if (cnt == 0) begin
      exp_q.push_back({2'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    end else begin
      for (int r = 0; r < cnt; r++) begin
        for (int b = PW - 1; b >= 0; b--)
          exp_q.push_back({2'd1, pat[b], 1'b1, 1'b1, 1'b0});
        if (r < cnt - 1)
          for (int g = 0; g < gap; g++)
            exp_q.push_back({2'd2, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      exp_q.push_back({2'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    exp_q.push_back({2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // Called at a negedge; start is sampled at the next posedge.
  task automatic run_txn(input string tag, input logic use_def, input logic [PW-1:0] pat,
                         input int cnt, input int gap, input int repulse_at);
    logic [PW-1:0] eff;
    logic [5:0]    e;
    int            k;
    eff = use_def ? 4'b1011 : pat;
    push_model(eff, cnt, gap);
    use_default = use_def;
    pattern_in  = pat;
    count_in    = CW'(cnt);
    gap_in      = GW'(gap);
    start       = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      start = 1'b0;
      e = exp_q.pop_front();
      check(tag, e);
      if (k == repulse_at) begin
        start       = 1'b1;
        use_default = ~use_def;
        pattern_in  = ~pat;
        count_in    = CW'(cnt + 1);
        gap_in      = GW'(gap + 1);
      end
      k++;
    end
    start = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    start       = 1'b0;
    use_default = 1'b0;
    pattern_in  = '0;
    count_in    = '0;
    gap_in      = '0;
    repeat (3) @(negedge clock);
    check("reset_state", 6'b00_0000);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", 6'b00_0000);

    run_txn("default_x1", 1'b1, 4'b0110, 1, 0, -1);
    run_txn("p1100_x2_gap3", 1'b0, 4'b1100, 2, 3, -1);
    run_txn("default_x3_gap0", 1'b1, 4'b0000, 3, 0, -1);
    run_txn("count_zero", 1'b0, 4'b1111, 0, 2, -1);
    run_txn("restart_ignored", 1'b0, 4'b1001, 2, 1, 1);
    run_txn("restart_in_gap", 1'b0, 4'b0111, 2, 2, 5);
    run_txn("back_to_back", 1'b0, 4'b1010, 1, 0, -1);

    // Reset while the bit at index 2 of a count=2 transfer is on the line.
    use_default = 1'b0;
    pattern_in  = 4'b1100;
    count_in    = 4'd2;
    gap_in      = 4'd1;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("abort_bit3", {2'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    @(negedge clock);
    check("abort_bit2", {2'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    reset = 1'b1;
    @(negedge clock);
    check("abort_reset", 6'b00_0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_no_done", 6'b00_0000);
    end
    run_txn("after_abort", 1'b0, 4'b1101, 2, 1, -1);

    for (int i = 0; i < 4; i++) begin
      run_txn("random", 1'(i % 2), 4'($urandom_range(0, 15)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
